// File: rtl/fir_ntap_prog.sv
// fir_ntap_prog: parametrised N-tap signed FIR filter with run-time programmable
// coefficients and a valid-qualified input stream.
//
// Parameters:
//   W     input sample width (signed)
//   TAPS  number of taps (2..32)
//   CW    coefficient width (signed)
//   AW    coefficient address width (derived, do not override)
//   OW    output width (derived, full precision)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   sample strobe; a is accepted on every edge where it is high
//   a          signed input sample
//   coef_we    coefficient write enable
//   coef_addr  tap index to write (0 = newest sample); indices >= TAPS are ignored
//   coef_data  signed coefficient value
//   out_valid  s holds a new result this cycle
//   s          signed filter output
//   sat        saturation flag (only driven when FIR_SAT_EN is defined)
//
// Optional feature: define FIR_SAT_EN to clamp each result to the W-bit signed
// range and flag clamping on sat. Otherwise s is full precision and sat is 0.
//
// Latency: sample accepted at edge n -> products at n+1 -> s/out_valid at n+2.
// Reset leaves every coefficient at 1, giving a plain running sum.

module fir_ntap_prog #(
    parameter int W    = 16,
    parameter int TAPS = 4,
    parameter int CW   = 8,
    parameter int AW   = $clog2(TAPS),
    parameter int OW   = W + CW + $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [W-1:0]  a,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 out_valid,
    output logic signed [OW-1:0] s,
    output logic                 sat
);

    localparam int PW = W + CW;

    logic signed [W-1:0]  x_q [TAPS];
    logic signed [CW-1:0] c_q [TAPS];
    logic signed [PW-1:0] p_q [TAPS];
    logic signed [OW-1:0] sum_full;
    logic signed [OW-1:0] s_d;
    logic signed [OW-1:0] s_q;
    logic                 v1_q;
    logic                 v2_q;
    logic                 out_valid_q;
    logic                 addr_ok;

    // With a power-of-two tap count every representable address is legal.
    if ((1 << AW) == TAPS) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok = (32'(coef_addr) < 32'(TAPS));
    end

    // Delay line: shifts only on accepted samples, so gaps never insert zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (in_valid) begin
            x_q[0] <= a;
            for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        end
    end

    // Coefficient bank; reset to unit weights.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) c_q[k] <= {{(CW-1){1'b0}}, 1'b1};
        end else if (coef_we && addr_ok) begin
            c_q[coef_addr] <= coef_data;
        end
    end

    // Stage P: a coefficient written alongside a sample is already in c_q here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) p_q[k] <= '0;
        end else if (v1_q) begin
            for (int k = 0; k < TAPS; k++) p_q[k] <= PW'(x_q[k]) * PW'(c_q[k]);
        end
    end

    always_comb begin
        sum_full = '0;
        for (int k = 0; k < TAPS; k++) sum_full = sum_full + OW'(p_q[k]);
    end

`ifdef FIR_SAT_EN
    localparam logic signed [OW-1:0] SatMax = {{(OW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [OW-1:0] SatMin = {{(OW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic clip;
    logic sat_q;

    always_comb begin
        clip = 1'b0;
        s_d  = sum_full;
        if (sum_full > SatMax) begin
            s_d  = SatMax;
            clip = 1'b1;
        end else if (sum_full < SatMin) begin
            s_d  = SatMin;
            clip = 1'b1;
        end
    end

    // Updated only on result edges so it holds between results.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_q <= 1'b0;
        end else if (v2_q) begin
            sat_q <= clip;
        end
    end

    assign sat = sat_q;
`else
    assign s_d = sum_full;
    assign sat = 1'b0;
`endif

    // Stage S and valid pipe.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_q         <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (v2_q) s_q <= s_d;
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
        end
    end

    assign s         = s_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_ntap_prog.sv
// Directed self-checking bench for fir_ntap_prog at W=16, TAPS=4, CW=8.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.

module tb_fir_ntap_prog;

    localparam int W    = 16;
    localparam int TAPS = 4;
    localparam int CW   = 8;
    localparam int AW   = $clog2(TAPS);
    localparam int OW   = W + CW + $clog2(TAPS);

`ifdef FIR_SAT_EN
    localparam bit SatBuild = 1'b1;
`else
    localparam bit SatBuild = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic signed [W-1:0]  a;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 out_valid;
    logic signed [OW-1:0] s;
    logic                 sat;

    int checks = 0;
    int errors = 0;

    fir_ntap_prog #(
        .W    (W),
        .TAPS (TAPS),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .s         (s),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive in_valid/a, advance, then check out_valid, s and sat.
    task automatic cyc(input string tag, input bit v, input int av, input bit eov,
                       input longint es, input bit esat);
        in_valid = v;
        a        = W'(av);
        tick();
        check({tag, ".ov"}, out_valid, eov);
        check({tag, ".s"}, $signed(s), es);
        check({tag, ".sat"}, sat, esat);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic wr_coef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = CW'(data);
        tick();
        coef_we   = 1'b0;
    endtask

    longint p_ext;
    longint e1, e2, e3, e4;
    bit     es;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst.ov", out_valid, 0);
        check("rst.s", $signed(s), 0);
        check("rst.sat", sat, 0);

        // Default coefficients: running sum of 1..5.
        cyc("dflt1", 1, 1, 0, 0, 0);
        cyc("dflt2", 1, 2, 0, 0, 0);
        cyc("dflt3", 1, 3, 1, 1, 0);
        cyc("dflt4", 1, 4, 1, 3, 0);
        cyc("dflt5", 1, 5, 1, 6, 0);
        cyc("dflt6", 0, 0, 1, 10, 0);
        cyc("dflt7", 0, 0, 1, 14, 0);
        cyc("dflt8", 0, 0, 0, 14, 0);

        // Programmed impulse response c = {3,-2,5,7}.
        do_reset();
        wr_coef(0, 3);
        wr_coef(1, -2);
        wr_coef(2, 5);
        wr_coef(3, 7);
        cyc("imp1", 1, 1, 0, 0, 0);
        cyc("imp2", 1, 0, 0, 0, 0);
        cyc("imp3", 1, 0, 1, 3, 0);
        cyc("imp4", 1, 0, 1, -2, 0);
        cyc("imp5", 1, 0, 1, 5, 0);
        cyc("imp6", 0, 0, 1, 7, 0);
        cyc("imp7", 0, 0, 1, 0, 0);

        // Extreme values: each product is (-128)*(-32768) = 4194304.
        do_reset();
        for (int k = 0; k < TAPS; k++) wr_coef(k, -128);
        p_ext = 64'sd4194304;
        e1 = SatBuild ? 64'sd32767 : p_ext;
        e2 = SatBuild ? 64'sd32767 : 2 * p_ext;
        e3 = SatBuild ? 64'sd32767 : 3 * p_ext;
        e4 = SatBuild ? 64'sd32767 : 4 * p_ext;
        es = SatBuild;
        cyc("ext1", 1, -32768, 0, 0, 0);
        cyc("ext2", 1, -32768, 0, 0, 0);
        cyc("ext3", 1, -32768, 1, e1, es);
        cyc("ext4", 1, -32768, 1, e2, es);
        cyc("ext5", 0, 0, 1, e3, es);
        cyc("ext6", 0, 0, 1, e4, es);
        cyc("ext7", 0, 0, 0, e4, es);

        // Gapped input: outputs keep the input spacing, s holds in between.
        do_reset();
        cyc("gap1", 1, 10, 0, 0, 0);
        cyc("gap2", 0, 0, 0, 0, 0);
        cyc("gap3", 0, 0, 1, 10, 0);
        cyc("gap4", 0, 0, 0, 10, 0);
        cyc("gap5", 1, 20, 0, 10, 0);
        cyc("gap6", 0, 0, 0, 10, 0);
        cyc("gap7", 1, 30, 1, 30, 0);
        cyc("gap8", 0, 0, 0, 30, 0);
        cyc("gap9", 0, 0, 1, 60, 0);
        cyc("gap10", 0, 0, 0, 60, 0);

        // Coefficient written on the accept edge applies to that sample.
        // At TAPS=4 an address of 4 is not representable in AW bits.
        do_reset();
        coef_we   = 1'b1;
        coef_addr = AW'(0);
        coef_data = CW'(2);
        cyc("ct1", 1, 5, 0, 0, 0);
        coef_we   = 1'b0;
        cyc("ct2", 0, 0, 0, 0, 0);
        cyc("ct3", 0, 0, 1, 10, 0);
        // Write c[1]=3 on the edge where this sample's products register: no effect.
        cyc("ct4", 1, 1, 0, 10, 0);
        coef_we   = 1'b1;
        coef_addr = AW'(1);
        coef_data = CW'(3);
        cyc("ct5", 0, 0, 0, 10, 0);
        coef_we   = 1'b0;
        cyc("ct6", 0, 0, 1, 7, 0);

        // Reset with two samples in flight: neither produces a result.
        cyc("mid1", 1, 7, 0, 7, 0);
        cyc("mid2", 1, 8, 0, 7, 0);
        do_reset();
        check("mid.rst.ov", out_valid, 0);
        check("mid.rst.s", $signed(s), 0);
        cyc("mid3", 0, 0, 0, 0, 0);
        cyc("mid4", 0, 0, 0, 0, 0);
        cyc("mid5", 0, 0, 0, 0, 0);
        // Impulse after reset shows all coefficients back at 1.
        cyc("post1", 1, 1, 0, 0, 0);
        cyc("post2", 1, 0, 0, 0, 0);
        cyc("post3", 1, 0, 1, 1, 0);
        cyc("post4", 1, 0, 1, 1, 0);
        cyc("post5", 1, 0, 1, 1, 0);
        cyc("post6", 0, 0, 1, 1, 0);
        cyc("post7", 0, 0, 1, 0, 0);
        cyc("post8", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
